// File: rtl/pos_dec_pkg.sv
// pos_dec_pkg: shared widths, FSM state encoding and decode-mode selection
// for the registered 3-to-8 position decoder.
// Build option: define POS_DECODER_THERMO_EN to switch the decode from
// one-hot (8'b1 << p) to thermometer ((9'b1 << (p+1)) - 1).
package pos_dec_pkg;

  localparam int unsigned POS_W = 3;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned CNT_W = 8;

  // Prefixed so the literals never collide with the HOLD/GAP parameters.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef enum logic {
    DEC_ONEHOT = 1'b0,
    DEC_THERMO = 1'b1
  } dec_mode_t;

`ifdef POS_DECODER_THERMO_EN
  localparam dec_mode_t DEC_MODE = DEC_THERMO;
`else
  localparam dec_mode_t DEC_MODE = DEC_ONEHOT;
`endif

endpackage : pos_dec_pkg

// File: rtl/pos_dec_comb.sv
// pos_dec_comb: purely combinational 3-bit position to 8-bit line decode.
// The mode (one-hot or thermometer) comes from pos_dec_pkg::DEC_MODE.
// Ports:
//   pos    in  POS_W  position code 0..7
//   dec_c  out OUT_W  decoded lines (combinational)
module pos_dec_comb
  import pos_dec_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  output logic [OUT_W-1:0] dec_c
);

  // Bit i is set when i == pos (one-hot) or i <= pos (thermometer).
  always_comb begin
    dec_c = '0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      if (DEC_MODE == DEC_THERMO) begin
        dec_c[i] = (i <= int'(pos));
      end else begin
        dec_c[i] = (i == int'(pos));
      end
    end
  end

endmodule : pos_dec_comb

// File: rtl/pos_decoder_3to8.sv
// pos_decoder_3to8: registered 3-to-8 position decoder with a valid/ready
// input handshake. Each accepted code is driven for HOLD cycles, followed by
// GAP all-zero cycles, then the block returns to idle.
// Build option: POS_DECODER_THERMO_EN selects thermometer decode (see pkg).
// Parameters:
//   HOLD  cycles each code is driven, 1..255
//   GAP   zero cycles after each hold, 0..255
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   async active-low reset
//   flush      in   synchronous abort back to idle
//   in_valid   in   pos is valid
//   in_ready   out  combinational: idle and not flushing
//   pos        in   position code
//   out_data   out  registered decoded lines
//   out_valid  out  registered, high during the hold phase
//   busy       out  registered, high during hold or gap
//   done       out  registered, high on the last hold cycle
module pos_decoder_3to8
  import pos_dec_pkg::*;
#(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] pos,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam bit               HAS_GAP = (GAP != 0);
  localparam logic [CNT_W-1:0] GAP_LD  = HAS_GAP ? CNT_W'(GAP - 1) : '0;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [OUT_W-1:0]   dec;
  logic [OUT_W-1:0]   out_data_d;
  logic               out_valid_d;
  logic               busy_d;
  logic               done_d;

  assign in_ready = (state == ST_IDLE) && !flush;

  // Decode the next-cycle code so out_data is valid in the first HOLD cycle.
  pos_dec_comb u_dec (
    .pos   (pos_d),
    .dec_c (dec)
  );

  // Next-state, counter and next-output logic; outputs follow state_d.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pos_d   = pos_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
            pos_d   = pos;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            state_d = HAS_GAP ? ST_GAP : ST_IDLE;
            cnt_d   = GAP_LD;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    out_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_HOLD) && (cnt_d == '0);
    out_data_d  = out_valid_d ? dec : '0;
  end

  // State, counter, latched code and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pos_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      pos_q     <= pos_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule : pos_decoder_3to8

// File: tb/tb_pos_decoder_3to8.sv
// tb_pos_decoder_3to8: self-checking bench for pos_decoder_3to8.
// Two instances share clk/rst_n: "a" with HOLD=4/GAP=1, "b" with HOLD=1/GAP=0.
// Each is compared every cycle against a model that tracks only whether a
// code is active, how many edges have passed since it was accepted, and the
// latched code. Honours POS_DECODER_THERMO_EN for the expected decode.
module tb_pos_decoder_3to8;

  localparam int HOLD_A = 4;
  localparam int GAP_A  = 1;
  localparam int HOLD_B = 1;
  localparam int GAP_B  = 0;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_flush = 1'b0, a_valid = 1'b0;
  logic [2:0] a_pos   = 3'd0;
  logic       a_ready, a_ov, a_busy, a_done;
  logic [7:0] a_data;

  logic       b_flush = 1'b0, b_valid = 1'b0;
  logic [2:0] b_pos   = 3'd0;
  logic       b_ready, b_ov, b_busy, b_done;
  logic [7:0] b_data;

  always #5 clk = ~clk;

  pos_decoder_3to8 #(.HOLD(HOLD_A), .GAP(GAP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_valid),
    .in_ready(a_ready), .pos(a_pos), .out_data(a_data), .out_valid(a_ov),
    .busy(a_busy), .done(a_done)
  );

  pos_decoder_3to8 #(.HOLD(HOLD_B), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_valid),
    .in_ready(b_ready), .pos(b_pos), .out_data(b_data), .out_valid(b_ov),
    .busy(b_busy), .done(b_done)
  );

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  bit act[2];
  int age[2];
  int code[2];
  bit acc[2];
  int dones[2];
  int last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic int hold_of(input int i);
    return (i == 0) ? HOLD_A : HOLD_B;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP_A : GAP_B;
  endfunction

  function automatic logic [7:0] ref_dec(input int p);
`ifdef POS_DECODER_THERMO_EN
    return 8'((2 ** (p + 1)) - 1);
`else
    return 8'(2 ** p);
`endif
  endfunction

  // One clock edge of the reference: a code lives for HOLD+GAP edges.
  task automatic model_step(input int i, input bit v, input int p, input bit f);
    acc[i] = 1'b0;
    if (f) begin
      act[i] = 1'b0;
    end else if (act[i]) begin
      age[i]++;
      if (age[i] >= hold_of(i) + gap_of(i)) act[i] = 1'b0;
    end else if (v) begin
      act[i]  = 1'b1;
      age[i]  = 0;
      code[i] = p;
      acc[i]  = 1'b1;
    end
  endtask

  task automatic compare(input int i, input string nm, input logic [7:0] d, input bit ov,
                         input bit bz, input bit dn, input bit rdy, input bit f);
    bit ev;
    ev = act[i] && (age[i] < hold_of(i));
    check({nm, "_data"},  32'(d),   32'(ev ? ref_dec(code[i]) : 8'h00));
    check({nm, "_valid"}, 32'(ov),  32'(ev));
    check({nm, "_busy"},  32'(bz),  32'(act[i]));
    check({nm, "_done"},  32'(dn),  32'(ev && (age[i] == hold_of(i) - 1)));
    check({nm, "_ready"}, 32'(rdy), 32'(!act[i] && !f));
    if (dn) dones[i]++;
  endtask

  task automatic tick();
    @(posedge clk);
    cycle++;
    model_step(0, a_valid, int'(a_pos), a_flush);
    model_step(1, b_valid, int'(b_pos), b_flush);
    #1;
    compare(0, "a", a_data, a_ov, a_busy, a_done, a_ready, a_flush);
    compare(1, "b", b_data, b_ov, b_busy, b_done, b_ready, b_flush);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0;
      age[i] = 0;
      acc[i] = 1'b0;
    end
  endtask

  initial begin
    int n;
    int d0;
    model_reset();
    dones[0] = 0;
    dones[1] = 0;

    // Reset held while clocking with in_valid high: nothing may start.
    a_valid = 1'b1; a_pos = 3'd3;
    b_valid = 1'b1; b_pos = 3'd5;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_a_data", 32'(a_data), 32'h0);
      check("rst_a_busy", 32'(a_busy), 32'h0);
      check("rst_a_valid", 32'(a_ov), 32'h0);
      check("rst_a_done", 32'(a_done), 32'h0);
      check("rst_b_data", 32'(b_data), 32'h0);
      check("rst_b_busy", 32'(b_busy), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1;
    check("rst_a_ready", 32'(a_ready), 32'h1);
    check("rst_b_ready", 32'(b_ready), 32'h1);

    // Back-to-back sweep of every code on instance a.
    d0 = dones[0];
    last_acc = 0;
    for (int p = 0; p < 8; p++) begin
      a_pos   = 3'(p);
      a_valid = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (!acc[0] && n < 20);
      check("sweep_accept", 32'(acc[0]), 32'h1);
      if (p > 0) check("sweep_spacing", 32'(cycle - last_acc), 32'(HOLD_A + GAP_A + 1));
      last_acc = cycle;
    end
    a_valid = 1'b0;
    repeat (HOLD_A + GAP_A + 1) tick();
    check("sweep_dones", 32'(dones[0] - d0), 32'd8);

    // HOLD=1/GAP=0 with in_valid held: a code every other cycle.
    d0 = dones[1];
    b_pos = 3'd5;
    b_valid = 1'b1;
    repeat (20) tick();
    b_valid = 1'b0;
    repeat (2) tick();
    check("b_period_dones", 32'(dones[1] - d0), 32'd10);

    // Flush on the second HOLD cycle of pos 6.
    a_pos = 3'd6;
    a_valid = 1'b1;
    tick();
    check("flush_setup_accept", 32'(acc[0]), 32'h1);
    a_valid = 1'b0;
    tick();
    a_flush = 1'b1;
    d0 = dones[0];
    tick();
    check("flush_data_cleared", 32'(a_data), 32'h0);
    a_flush = 1'b0;
    repeat (HOLD_A + GAP_A + 1) tick();
    check("flush_no_done", 32'(dones[0] - d0), 32'd0);

    // flush together with in_valid in IDLE: nothing accepted.
    a_flush = 1'b1;
    a_valid = 1'b1;
    a_pos   = 3'd1;
    #1;
    check("flush_idle_ready", 32'(a_ready), 32'h0);
    tick();
    check("flush_idle_noaccept", 32'(acc[0]), 32'h0);
    check("flush_idle_busy", 32'(a_busy), 32'h0);
    a_flush = 1'b0;
    a_valid = 1'b0;
    tick();

    // Backpressure: pos changes during HOLD must not disturb the output.
    a_pos = 3'd2;
    a_valid = 1'b1;
    tick();
    check("bp_accept", 32'(acc[0]), 32'h1);
    repeat (HOLD_A - 1) begin
      a_pos = 3'($urandom_range(0, 7));
      tick();
      check("bp_data_held", 32'(a_data), 32'(ref_dec(2)));
    end
    a_valid = 1'b0;
    repeat (HOLD_A + GAP_A) tick();

    // Random traffic on both instances.
    repeat (400) begin
      a_valid = 1'($urandom_range(0, 1));
      a_pos   = 3'($urandom_range(0, 7));
      a_flush = ($urandom_range(0, 15) == 0);
      b_valid = 1'($urandom_range(0, 1));
      b_pos   = 3'($urandom_range(0, 7));
      b_flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    a_valid = 1'b0; a_flush = 1'b0;
    b_valid = 1'b0; b_flush = 1'b0;
    repeat (HOLD_A + GAP_A + 1) tick();

    // Asynchronous reset in the middle of a HOLD phase.
    a_pos = 3'd4;
    a_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc[0] && n < 20);
    check("areset_accept", 32'(acc[0]), 32'h1);
    a_valid = 1'b0;
    tick();
    check("areset_pre_valid", 32'(a_ov), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_data", 32'(a_data), 32'h0);
    check("areset_valid", 32'(a_ov), 32'h0);
    check("areset_busy", 32'(a_busy), 32'h0);
    check("areset_done", 32'(a_done), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pos_decoder_3to8
